seq_mult8_ctrl: RTL

Sequential controller for the 8x8 recursive multiplier. It time-shares one 4x4 multiplier core across the four nibble partial products (LL, LH, HL, HH). It accumulates the products, with shifts, into a 16-bit result, trading latency for three fewer 4x4 cores. It sits between an operand source and a result sink, both using valid/ready handshakes, and skips steps whose nibble product is zero.

---
 rtl/mult_seq_pkg.sv | 52 +++++
 rtl/mult4_core.sv | 43 ++++
 rtl/seq_mult8_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: shared types and constants for the sequential 8x8 multiplier
// controller (seq_mult8_ctrl) and its shared 4x4 core (mult4_core).
package mult_seq_pkg;

  // Operand, nibble and result widths.
  localparam int OP_W  = 8;
  localparam int NIB_W = 4;
  localparam int RES_W = 16;

  // Controller states: idle, one state per partial-product step, result hold.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LL   = 3'd1,
    LH   = 3'd2,
    HL   = 3'd3,
    HH   = 3'd4,
    DONE = 3'd5
  } state_t;

  // Step indices, which are also the bit positions in the step mask {HH, HL, LH, LL}.
  localparam int STEP_LL = 0;
  localparam int STEP_LH = 1;
  localparam int STEP_HL = 2;
  localparam int STEP_HH = 3;

  // Left shift applied to each step's 8-bit partial product before accumulation.
  localparam logic [3:0] SH_LL  = 4'd0;
  localparam logic [3:0] SH_MID = 4'd4;
  localparam logic [3:0] SH_HH  = 4'd8;

  // Map a step index to its FSM state.
  function automatic state_t step_state(input int idx);
    step_state = HH;
    case (idx)
      STEP_LL: step_state = LL;
      STEP_LH: step_state = LH;
      STEP_HL: step_state = HL;
      default: step_state = HH;
    endcase
  endfunction

  // First enabled step strictly after step index 'after' (-1 = from the start);
  // DONE when no enabled step remains.
  function automatic state_t next_step(input logic [3:0] m, input int after);
    next_step = DONE;
    // Walk downwards so the lowest qualifying index is the one that sticks.
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (i > after)) next_step = step_state(i);
    end
  endfunction

endpackage

// File: rtl/mult4_core.sv
// mult4_core: combinational 4x4 multiplier shared by all controller steps.
// Build option EXACT_MULT_EN: defined -> exact product; undefined -> the
// approximate M2_4x4 core (four approximate 2x2 blocks, recursively combined).
module mult4_core
  import mult_seq_pkg::*;
(
  input  logic [NIB_W-1:0]   op_a,
  input  logic [NIB_W-1:0]   op_b,
  output logic [2*NIB_W-1:0] prod
);

`ifdef EXACT_MULT_EN

  // Exact 4x4 product.
  always_comb begin
    prod = (2*NIB_W)'(op_a) * (2*NIB_W)'(op_b);
  end

`else

  // Approximate 2x2 block: exact except 3x3, which yields 7 (3-bit output).
  function automatic logic [2:0] mul2_approx(input logic [1:0] u, input logic [1:0] v);
    mul2_approx = {u[1] & v[1], (u[1] & v[0]) | (u[0] & v[1]), u[0] & v[0]};
  endfunction

  logic [2:0] p_ll, p_lh, p_hl, p_hh;

  assign p_ll = mul2_approx(op_a[1:0], op_b[1:0]);
  assign p_lh = mul2_approx(op_a[1:0], op_b[3:2]);
  assign p_hl = mul2_approx(op_a[3:2], op_b[1:0]);
  assign p_hh = mul2_approx(op_a[3:2], op_b[3:2]);

  // Recombine the four 2x2 partial products with their 2-bit-granular shifts.
  always_comb begin
    prod = (2*NIB_W)'(p_ll)
         + ((2*NIB_W)'(p_lh) << 2)
         + ((2*NIB_W)'(p_hl) << 2)
         + ((2*NIB_W)'(p_hh) << 4);
  end

`endif

endmodule

// File: rtl/seq_mult8_ctrl.sv
// seq_mult8_ctrl: sequential 8x8 multiplier controller. One shared 4x4 core is
// stepped through the LL, LH, HL and HH nibble products, which are shifted and
// summed into a 16-bit accumulator. Steps with a zero nibble are skipped when
// SKIP_ZERO = 1. Valid/ready handshakes on both sides, one operation in flight.
// Build option EXACT_MULT_EN selects the exact core; otherwise the approximate
// M2_4x4 core is used (see mult4_core).
module seq_mult8_ctrl
  import mult_seq_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] y,
  output logic             busy
);

  state_t             state, state_nxt;
  logic [OP_W-1:0]    a_q, b_q;
  logic [RES_W-1:0]   acc, acc_sum;
  logic [3:0]         mask, mask_new;
  logic [NIB_W-1:0]   core_a, core_b;
  logic [2*NIB_W-1:0] core_p;
  logic [3:0]         shamt;
  logic               accept;
  logic               in_step;

  // Step mask {HH, HL, LH, LL}: a step is dropped when one of its nibbles is zero.
  function automatic logic [3:0] step_mask(input logic [OP_W-1:0] ma, input logic [OP_W-1:0] mb);
    logic al, ah, bl, bh;
    al = |ma[NIB_W-1:0];
    ah = |ma[OP_W-1:NIB_W];
    bl = |mb[NIB_W-1:0];
    bh = |mb[OP_W-1:NIB_W];
    if (SKIP_ZERO) step_mask = {ah & bh, ah & bl, al & bh, al & bl};
    else           step_mask = 4'hF;
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign mask_new = step_mask(a, b);
  assign in_step  = (state == LL) || (state == LH) || (state == HL) || (state == HH);

  // Shared core: the only 4x4 multiplier in the block.
  mult4_core u_core (
    .op_a (core_a),
    .op_b (core_b),
    .prod (core_p)
  );

  // Drive the core with the current step's nibble pair and pick its shift.
  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    core_a = '0;
    core_b = '0;
    shamt  = SH_LL;
    case (state)
      LL: begin
        core_a = a_q[NIB_W-1:0];
        core_b = b_q[NIB_W-1:0];
        shamt  = SH_LL;
      end
      LH: begin
        core_a = a_q[NIB_W-1:0];
        core_b = b_q[OP_W-1:NIB_W];
        shamt  = SH_MID;
      end
      HL: begin
        core_a = a_q[OP_W-1:NIB_W];
        core_b = b_q[NIB_W-1:0];
        shamt  = SH_MID;
      end
      HH: begin
        core_a = a_q[OP_W-1:NIB_W];
        core_b = b_q[OP_W-1:NIB_W];
        shamt  = SH_HH;
      end
      default: ;
    endcase
  end

  // Accumulator update for the current step; the sum wraps modulo 2^16.
  assign acc_sum = acc + (RES_W'(core_p) << shamt);

  // Next-state logic: walk the enabled steps in LL, LH, HL, HH order.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = next_step(mask_new, -1);
      LL:      state_nxt = next_step(mask, STEP_LL);
      LH:      state_nxt = next_step(mask, STEP_LH);
      HL:      state_nxt = next_step(mask, STEP_HL);
      HH:      state_nxt = next_step(mask, STEP_HH);
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand latch, step mask and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      mask <= '0;
    end else if (accept) begin
      a_q  <= a;
      b_q  <= b;
      acc  <= '0;
      mask <= mask_new;
    end else if (in_step) begin
      acc  <= acc_sum;
    end
  end

  // Result register and out_valid: load on entry to DONE, clear on transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= '0;
      out_valid <= 1'b0;
    end else if ((state != DONE) && (state_nxt == DONE)) begin
      // An empty mask goes straight from IDLE, where the freshly cleared sum is zero.
      y         <= in_step ? acc_sum : '0;
      out_valid <= 1'b1;
    end else if ((state == DONE) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
